adler32_frame_ctrl: RTL and testbench

Frame sequencer for the Adler-32 byte accumulator. It buffers an input byte stream with valid/ready/last framing in a small FIFO. It drives the accumulator's run/data inputs so that every frame reaches the accumulator as a gapless burst, with a mandatory re-init cycle between frames. It captures the final 32-bit checksum, byte count and error status into a valid/ready result port.

---
 rtl/adler32_pkg.sv | 15 +
 rtl/adler32_byte_fifo.sv | 61 ++++++
 rtl/adler32_frame_ctrl.sv | 142 ++++++++++++++
 tb/tb_adler32_frame_ctrl.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adler32_pkg.sv
// Shared types and constants for the Adler-32 frame sequencer and its accumulator.
package adler32_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RUN,
        ST_FLUSH,
        ST_DONE,
        ST_DROP
    } frame_state_t;

    localparam int          ADLER_MOD  = 65521;
    localparam logic [31:0] ADLER_INIT = 32'h0000_0001;

endpackage

// File: rtl/adler32_byte_fifo.sv
// Synchronous first-word-fall-through FIFO holding {last,data} entries for the frame sequencer.
module adler32_byte_fifo
    import adler32_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int WIDTH = 9
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    output logic [WIDTH-1:0]       pop_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int             AW       = $clog2(DEPTH);
    localparam logic [AW:0]    FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full     = (count == FULL_CNT);
    assign empty    = (count == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/adler32_frame_ctrl.sv
// Buffers framed input bytes and feeds each frame to the Adler-32 accumulator as a gapless
// burst, then captures checksum, length and underrun status into a valid/ready result port.
module adler32_frame_ctrl
    import adler32_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int LEN_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_data,
    input  logic             in_last,
    output logic             acc_run,
    output logic [7:0]       acc_data,
    input  logic [31:0]      acc_checksum,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [31:0]      res_checksum,
    output logic [LEN_W-1:0] res_len,
    output logic             res_err
);

    localparam int          CW       = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    frame_state_t     state;
    logic             fifo_pop;
    logic             fifo_full;
    logic             fifo_empty;
    logic [8:0]       fifo_data;
    logic [CW-1:0]    fifo_count;
    logic [CW-1:0]    last_cnt;
    logic             push;
    logic             pop_last;
    logic [LEN_W-1:0] len;
    logic             err;
    logic             tail;

    assign in_ready = !fifo_full;
    assign push     = in_valid && in_ready;
    assign pop_last = fifo_pop && fifo_data[8];

    adler32_byte_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (9)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data ({in_last, in_data}),
        .pop       (fifo_pop),
        .pop_data  (fifo_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    always_comb begin
        fifo_pop = 1'b0;
        case (state)
            ST_RUN:  fifo_pop = !tail && !fifo_empty;
            ST_DROP: fifo_pop = !fifo_empty;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_cnt <= '0;
        end else begin
            case ({push && in_last, pop_last})
                2'b10:   last_cnt <= last_cnt + 1'b1;
                2'b01:   last_cnt <= last_cnt - 1'b1;
                default: ;
            endcase
        end
    end

    // After the last byte is popped, RUN spends one more cycle (tail) so that the
    // accumulator absorbs it before FLUSH samples acc_checksum.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            acc_run      <= 1'b0;
            acc_data     <= '0;
            res_valid    <= 1'b0;
            res_checksum <= '0;
            res_len      <= '0;
            res_err      <= 1'b0;
            len          <= '0;
            err          <= 1'b0;
            tail         <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    acc_run <= 1'b0;
                    if (last_cnt != '0 || fifo_count == FULL_CNT) begin
                        state <= ST_RUN;
                        len   <= '0;
                        err   <= 1'b0;
                        tail  <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (tail || fifo_empty) begin
                        acc_run <= 1'b0;
                        err     <= !tail;
                        tail    <= 1'b0;
                        state   <= ST_FLUSH;
                    end else begin
                        acc_run  <= 1'b1;
                        acc_data <= fifo_data[7:0];
                        len      <= len + 1'b1;
                        tail     <= fifo_data[8];
                    end
                end
                ST_FLUSH: begin
                    res_checksum <= acc_checksum;
                    res_len      <= len;
                    res_err      <= err;
                    res_valid    <= 1'b1;
                    state        <= ST_DONE;
                end
                ST_DONE: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        state     <= err ? ST_DROP : ST_IDLE;
                    end
                end
                ST_DROP: begin
                    if (pop_last) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_adler32_frame_ctrl.sv
// Directed bench for adler32_frame_ctrl with a behavioural Adler-32 accumulator and scoreboard.
module tb_adler32_frame_ctrl;
    import adler32_pkg::*;

    localparam int DEPTH = 16;
    localparam int LEN_W = 16;

    typedef logic [7:0] byte_q_t[$];
    typedef struct {
        logic [31:0]      ck;
        logic [LEN_W-1:0] len;
        logic             err;
    } res_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [7:0]       in_data = '0;
    logic             in_last = 1'b0;
    logic             acc_run;
    logic [7:0]       acc_data;
    logic [31:0]      acc_checksum;
    logic             res_valid;
    logic             res_ready = 1'b1;
    logic [31:0]      res_checksum;
    logic [LEN_W-1:0] res_len;
    logic             res_err;

    int vectors = 0;
    int miscompares = 0;
    int results_seen = 0;

    logic [7:0]       fed_q[$];
    res_t             exp_q[$];
    logic [31:0]      got_ck  [0:15];
    logic [LEN_W-1:0] got_len [0:15];
    logic             got_err [0:15];

    always #5 clk = ~clk;

    adler32_frame_ctrl #(
        .DEPTH (DEPTH),
        .LEN_W (LEN_W)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .in_last      (in_last),
        .acc_run      (acc_run),
        .acc_data     (acc_data),
        .acc_checksum (acc_checksum),
        .res_valid    (res_valid),
        .res_ready    (res_ready),
        .res_checksum (res_checksum),
        .res_len      (res_len),
        .res_err      (res_err)
    );

    function automatic logic [31:0] adler_step(input logic [31:0] s, input logic [7:0] d);
        int a;
        int b;
        a = (int'(s[15:0]) + int'(d)) % ADLER_MOD;
        b = (int'(s[31:16]) + a) % ADLER_MOD;
        return {b[15:0], a[15:0]};
    endfunction

    function automatic logic [31:0] frame_adler(input byte_q_t bytes);
        logic [31:0] s;
        s = ADLER_INIT;
        foreach (bytes[i]) s = adler_step(s, bytes[i]);
        return s;
    endfunction

    // Accumulator beside the sequencer: reinitialises whenever engine_run is low.
    always @(posedge clk) begin
        if (!rst_n || !acc_run) acc_checksum <= ADLER_INIT;
        else                    acc_checksum <= adler_step(acc_checksum, acc_data);
    end

    function automatic void compare(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endfunction

    function automatic void fail_now(input string name);
        vectors++;
        miscompares++;
        $display("[TB] FAIL %s: got timeout/empty, expected event", name);
    endfunction

    // Per-cycle checker: fed bytes, gaps between bursts, result capture and hold stability.
    initial begin
        logic             prev_valid = 1'b0;
        logic             prev_ready = 1'b0;
        logic             prev_run = 1'b0;
        logic [31:0]      prev_ck = '0;
        logic [LEN_W-1:0] prev_len = '0;
        logic             prev_err = 1'b0;
        int               low_cnt = 2;
        res_t             e;
        forever begin
            @(negedge clk);
            #1;
            if (!rst_n) begin
                low_cnt = 2;
            end else begin
                if (acc_run) begin
                    if (!prev_run) compare("run_gap_ge2", 32'(low_cnt >= 2), 32'd1);
                    low_cnt = 0;
                    if (fed_q.size() == 0) fail_now("unexpected_feed");
                    else compare("acc_data", 32'(acc_data), 32'(fed_q.pop_front()));
                end else begin
                    low_cnt++;
                end
                if (res_valid) compare("run_while_result", 32'(acc_run), 32'd0);
                if (res_valid && prev_valid && !prev_ready) begin
                    compare("hold_checksum", res_checksum, prev_ck);
                    compare("hold_len", 32'(res_len), 32'(prev_len));
                    compare("hold_err", 32'(res_err), 32'(prev_err));
                end
                if (res_valid && !prev_valid) begin
                    if (exp_q.size() == 0) begin
                        fail_now("unexpected_result");
                    end else begin
                        e = exp_q.pop_front();
                        compare("model_checksum", res_checksum, e.ck);
                        compare("model_len", 32'(res_len), 32'(e.len));
                        compare("model_err", 32'(res_err), 32'(e.err));
                    end
                    if (results_seen < 16) begin
                        got_ck[results_seen]  = res_checksum;
                        got_len[results_seen] = res_len;
                        got_err[results_seen] = res_err;
                    end
                    results_seen++;
                end
            end
            prev_valid = rst_n && res_valid;
            prev_ready = res_ready;
            prev_run   = rst_n && acc_run;
            prev_ck    = res_checksum;
            prev_len   = res_len;
            prev_err   = res_err;
        end
    end

    task automatic push_byte(input logic [7:0] d, input logic l);
        int guard = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        while (!in_ready && guard < 500) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 500) fail_now("push_timeout");
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic apply_stimulus(input byte_q_t bytes);
        res_t e;
        e.ck  = frame_adler(bytes);
        e.len = LEN_W'(bytes.size());
        e.err = 1'b0;
        exp_q.push_back(e);
        foreach (bytes[i]) fed_q.push_back(bytes[i]);
        foreach (bytes[i]) push_byte(bytes[i], i == bytes.size() - 1);
    endtask

    task automatic wait_results(input int n);
        int guard = 0;
        while (results_seen < n && guard < 3000) begin
            @(negedge clk);
            guard++;
        end
        if (results_seen < n) fail_now("result_timeout");
    endtask

    task automatic check_output(input int idx, input logic [31:0] ck, input int len, input logic err);
        if (idx >= results_seen || idx >= 16) begin
            fail_now("result_missing");
        end else begin
            compare("lit_checksum", got_ck[idx], ck);
            compare("lit_len", 32'(got_len[idx]), 32'(len));
            compare("lit_err", 32'(got_err[idx]), 32'(err));
        end
    endtask

    task automatic check_reset_outputs();
        compare("rst_in_ready", 32'(in_ready), 32'd1);
        compare("rst_acc_run", 32'(acc_run), 32'd0);
        compare("rst_acc_data", 32'(acc_data), 32'd0);
        compare("rst_res_valid", 32'(res_valid), 32'd0);
        compare("rst_res_checksum", res_checksum, 32'd0);
        compare("rst_res_len", 32'(res_len), 32'd0);
        compare("rst_res_err", 32'(res_err), 32'd0);
    endtask

    initial begin
        byte_q_t abc;
        byte_q_t one_a;
        byte_q_t wiki;
        byte_q_t zeros;
        byte_q_t ones18;
        res_t    e;
        int      guard;

        abc   = '{8'h61, 8'h62, 8'h63};
        one_a = '{8'h61};
        wiki  = '{8'h57, 8'h69, 8'h6B, 8'h69, 8'h70, 8'h65, 8'h64, 8'h69, 8'h61};
        for (int i = 0; i < 41; i++) zeros.push_back(8'h00);
        for (int i = 0; i < 18; i++) ones18.push_back(8'h01);

        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs();
        rst_n = 1'b1;
        @(negedge clk);

        $display("[TB] single frame abc");
        apply_stimulus(abc);
        wait_results(1);
        check_output(0, 32'h024D0127, 3, 1'b0);

        $display("[TB] single byte then back-to-back Wikipedia");
        apply_stimulus(one_a);
        apply_stimulus(wiki);
        wait_results(3);
        check_output(1, 32'h00620062, 1, 1'b0);
        check_output(2, 32'h11E60398, 9, 1'b0);

        $display("[TB] frame longer than FIFO");
        apply_stimulus(zeros);
        wait_results(4);
        check_output(3, 32'h00290001, 41, 1'b0);

        $display("[TB] underrun with gap after byte 18");
        e.ck  = frame_adler(ones18);
        e.len = 18;
        e.err = 1'b1;
        exp_q.push_back(e);
        foreach (ones18[i]) fed_q.push_back(ones18[i]);
        for (int i = 0; i < 18; i++) push_byte(8'h01, 1'b0);
        repeat (30) @(negedge clk);
        push_byte(8'h01, 1'b0);
        push_byte(8'h01, 1'b1);
        apply_stimulus(abc);
        wait_results(6);
        check_output(4, 32'h00BD0013, 18, 1'b1);
        check_output(5, 32'h024D0127, 3, 1'b0);

        $display("[TB] result backpressure");
        res_ready = 1'b0;
        apply_stimulus(abc);
        apply_stimulus(wiki);
        wait_results(7);
        repeat (10) @(negedge clk);
        compare("bp_valid_held", 32'(res_valid), 32'd1);
        compare("bp_no_new_result", 32'(results_seen), 32'd7);
        res_ready = 1'b1;
        wait_results(8);
        check_output(6, 32'h024D0127, 3, 1'b0);
        check_output(7, 32'h11E60398, 9, 1'b0);

        $display("[TB] reset mid-run");
        repeat (4) @(negedge clk);
        for (int i = 0; i < 16; i++) fed_q.push_back(8'h05);
        for (int i = 0; i < 16; i++) push_byte(8'h05, 1'b0);
        guard = 0;
        while (!acc_run && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (!acc_run) fail_now("run_start_timeout");
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check_reset_outputs();
        fed_q.delete();
        exp_q.delete();
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        apply_stimulus(abc);
        wait_results(9);
        check_output(8, 32'h024D0127, 3, 1'b0);

        repeat (5) @(negedge clk);
        compare("fed_queue_drained", 32'(fed_q.size()), 32'd0);
        compare("result_queue_drained", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: got no finish, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
